pwm_multi_ch: RTL and testbench
===============================

PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

Interface
REQ-001 The block SHALL have parameter CH, default 4, giving the number of PWM channels (1..16).
REQ-002 The block SHALL have parameter W, default 8, giving the counter, period and duty width in bits (4..16).
REQ-003 Port clk  input  1  the single rising-edge clock for all logic.
REQ-004 Port rst_n  input  1  reset; synchronous and active-low.
REQ-005 Port enable  input  1  runs the counter when 1; 0 holds it idle.
REQ-006 Port load  input  1  one-cycle strobe that captures period, duty and mode into the pending registers.
REQ-007 Port period  input  W  counter terminal value P.
REQ-008 Port duty  input  CH*W  per-channel compare value; channel i occupies bits [i*W+W-1 : i*W].
REQ-009 Port mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-010 Port pwm_out  output  CH  registered PWM outputs.
REQ-011 Port period_tick  output  1  registered one-cycle pulse on the first cycle of each period.
REQ-012 Port update_pending  output  1  high while pending values wait to be applied.

Function
REQ-013 The block SHALL hold active registers (P_a, duty_a[CH], mode_a) and pending registers (P_p, duty_p[CH], mode_p, flag pend); pend SHALL drive update_pending.
REQ-014 When load=1, the pending registers SHALL capture the inputs and pend SHALL be set; a later load before apply SHALL overwrite them (latest wins).
REQ-015 Edge mode, enable=1: the counter SHALL count 0,1,...,P_a and then return to 0; period length = P_a+1 cycles.
REQ-016 Center mode, enable=1: the counter SHALL count up 0..P_a, then down P_a-1..1, then return to 0; period length = 2*P_a cycles for P_a>0.
REQ-017 P_a=0 in either mode: the counter SHALL stay at 0, and every cycle SHALL be a period end.
REQ-018 Period-end cycle: edge mode when cnt==P_a; center mode when direction is down and cnt==1, or when P_a==0.
REQ-019 On the clock edge that ends a period, if pend=1, active <= pending and pend SHALL clear; the new values SHALL apply from the first cycle of the next period.
REQ-020 If load coincides with a period end: the active registers SHALL take the previous pending contents (if pend was 1); the new inputs SHALL become pending with pend=1.
REQ-021 pwm_out[i] SHALL be registered with 1-cycle latency: pwm_out[i](n+1) = enable(n) AND (cnt(n) < duty_a[i](n)), compared unsigned on W bits.
REQ-022 duty_a[i]=0 SHALL give constant 0; duty_a[i] > P_a SHALL give constant 1 while enabled.
REQ-023 period_tick(n+1) SHALL be 1 exactly when enable(n)=1 and cnt(n)==0 with direction up; in steady state it SHALL pulse once per period.
REQ-024 While enable=0: cnt SHALL be held at 0 with direction up, and pwm_out and period_tick SHALL be 0 from the next edge.
REQ-025 While enable=0, a pending update SHALL apply on the next edge (idle counts as a period end).
REQ-026 On the 0->1 transition of enable, counting SHALL start from cnt=0; pwm_out SHALL follow 1 cycle later.
REQ-027 The counter SHALL be W bits and SHALL never wrap past P_a or underflow below 0.
REQ-028 A mode change SHALL take effect only through the pending/apply path; the counter SHALL restart at 0 with direction up on apply.

Reset
REQ-029 While rst_n=0 at a clock edge: cnt=0, direction=up, P_a=2^W-1, duty_a=0, mode_a=0, pending registers=0, pend=0.
REQ-030 While rst_n=0 at a clock edge: pwm_out=0, period_tick=0, update_pending=0; reset SHALL override load and enable.

Verification (CH=4, W=8)
REQ-031 rst_n=0 for 3 cycles with enable=1 and load=1 -> pwm_out=0000, period_tick=0, update_pending=0 throughout, and 1 cycle after release.
REQ-032 Edge: load P=9, duty={255,10,0,3} (ch3..ch0), enable=1 -> 10-cycle period; ch0 high 3 of 10 cycles; ch1=0; ch2=1; ch3=1; period_tick every 10 cycles.
REQ-033 Center: load P=4, mode=1, duty ch0=2 -> counter sequence 0,1,2,3,4,3,2,1 repeating; ch0 high 3 of 8 cycles (cnt 1,0,1) and centered on cnt=0.
REQ-034 Shadow: with P=9 running, load duty ch0=7 at cnt=4 -> ch0 keeps the old duty to period end; update_pending=1 until the apply edge; ch0 high 7 cycles in the next period.
REQ-035 Load coincident with the period-end cycle while pend=1 -> old pending applied at that edge; new values applied one period later; update_pending stays 1 in between.
REQ-036 rst_n=0 at cnt=6 mid-period -> next edge cnt=0, pwm_out=0000, active and pending registers at reset values, no residual update after release.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with a shared edge/center-aligned counter and
// shadowed period/duty/mode registers that switch over only at period ends.
module pwm_multi_ch #(
  parameter int CH = 4,
  parameter int W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            load,
  input  logic [W-1:0]    period,
  input  logic [CH*W-1:0] duty,
  input  logic            mode,
  output logic [CH-1:0]   pwm_out,
  output logic            period_tick,
  output logic            update_pending
);

  logic [W-1:0]         cnt_q, cnt_d;
  logic                 dn_q, dn_d;
  logic [W-1:0]         pa_q, pp_q;
  logic [CH-1:0][W-1:0] da_q, dp_q;
  logic                 ma_q, mp_q, pend_q;
  logic [CH-1:0]        pwm_q, pwm_d;
  logic                 tick_q;
  logic                 period_end;

  // The peak cycle (cnt==P_a) already counts as the down phase, so in center
  // mode the last cycle of every period is "down with cnt==1" even for P_a==1.
  always_comb begin
    period_end = 1'b0;
    cnt_d      = cnt_q;
    dn_d       = dn_q;
    if (!enable || pa_q == '0) period_end = 1'b1;
    else if (!ma_q)            period_end = (cnt_q == pa_q);
    else                       period_end = dn_q && (cnt_q == W'(1));

    if (period_end) begin
      cnt_d = '0;
      dn_d  = 1'b0;
    end else if (!ma_q) begin
      cnt_d = cnt_q + W'(1);
    end else if (dn_q) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q + W'(1);
      dn_d  = (cnt_d == pa_q);
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CH; i++) pwm_d[i] = enable && (cnt_q < da_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dn_q   <= 1'b0;
      pa_q   <= '1;
      da_q   <= '0;
      ma_q   <= 1'b0;
      pp_q   <= '0;
      dp_q   <= '0;
      mp_q   <= 1'b0;
      pend_q <= 1'b0;
      pwm_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dn_q   <= dn_d;
      pwm_q  <= pwm_d;
      tick_q <= enable && (cnt_q == '0) && !dn_q;
      if (period_end && pend_q) begin
        pa_q   <= pp_q;
        da_q   <= dp_q;
        ma_q   <= mp_q;
        pend_q <= 1'b0;
      end
      // A coincident load lands after the apply above: old pending goes
      // active, new inputs become pending.
      if (load) begin
        pp_q   <= period;
        dp_q   <= duty;
        mp_q   <= mode;
        pend_q <= 1'b1;
      end
    end
  end

  assign pwm_out        = pwm_q;
  assign period_tick    = tick_q;
  assign update_pending = pend_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized scoreboard bench for pwm_multi_ch; reference model tracks the
// position within a period and derives the counter value from it.
module tb_pwm_multi_ch;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst_n, enable, load, mode;
  logic [W-1:0]    period;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   pwm_out;
  logic            period_tick, update_pending;

  pwm_multi_ch #(.CH(CH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .period(period), .duty(duty), .mode(mode),
    .pwm_out(pwm_out), .period_tick(period_tick),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] pwm;
    logic          tick;
    logic          upd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  int m_k, m_pa, m_ma, m_pp, m_mp, m_pend;
  int m_da[CH];
  int m_dp[CH];

  function automatic int per_len();
    if (m_pa == 0) return 1;
    return m_ma ? 2 * m_pa : m_pa + 1;
  endfunction

  function automatic int cur_cnt();
    if (m_ma == 0 || m_k <= m_pa) return m_k;
    return 2 * m_pa - m_k;
  endfunction

  function automatic void model_reset();
    m_k = 0; m_pa = (1 << W) - 1; m_ma = 0; m_pp = 0; m_mp = 0; m_pend = 0;
    for (int i = 0; i < CH; i++) begin m_da[i] = 0; m_dp[i] = 0; end
  endfunction

  // Drive one cycle of inputs and push the outputs expected after that edge.
  task automatic step(input logic r, input logic en, input logic ld,
                      input int per, input int d[CH], input logic md);
    exp_t e;
    int   c;
    bit   pe;
    @(negedge clk); #1;
    rst_n = r; enable = en; load = ld; period = W'(per); mode = md;
    for (int i = 0; i < CH; i++) duty[i*W +: W] = W'(d[i]);
    if (!r) begin
      model_reset();
      e.pwm = '0; e.tick = 1'b0; e.upd = 1'b0;
    end else begin
      c = cur_cnt();
      for (int i = 0; i < CH; i++) e.pwm[i] = en && (c < m_da[i]);
      e.tick = en && (m_k == 0);
      pe = !en || (m_k == per_len() - 1);
      m_k = pe ? 0 : m_k + 1;
      if (pe && m_pend != 0) begin
        m_pa = m_pp; m_ma = m_mp; m_pend = 0;
        for (int i = 0; i < CH; i++) m_da[i] = m_dp[i];
      end
      if (ld) begin
        m_pp = per; m_mp = md; m_pend = 1;
        for (int i = 0; i < CH; i++) m_dp[i] = d[i];
      end
      e.upd = (m_pend != 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pwm_out", int'(pwm_out), int'(e.pwm));
      chk("period_tick", int'(period_tick), int'(e.tick));
      chk("update_pending", int'(update_pending), int'(e.upd));
    end
  end

  int dz[CH] = '{0, 0, 0, 0};

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 0, dz, 1'b0);
  endtask

  // Advance with enable high until the modelled counter reaches the target.
  task automatic wait_cnt(input int target);
    int guard = 0;
    while (cur_cnt() != target && guard < 600) begin
      step(1'b1, 1'b1, 1'b0, 0, dz, 1'b0);
      guard++;
    end
    chk("wait_cnt_timeout", guard < 600 ? 1 : 0, 1);
  endtask

  initial begin
    int d[CH];
    int p;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; period = '0; duty = '0; mode = 1'b0;
    model_reset();

    // reset overrides enable and load
    d = '{8'hA5, 8'h11, 8'h22, 8'h33};
    repeat (3) step(1'b0, 1'b1, 1'b1, 200, d, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, dz, 1'b0);

    // edge mode P=9, duty ch3..ch0 = 255,10,0,3
    d = '{3, 0, 10, 255};
    step(1'b1, 1'b0, 1'b1, 9, d, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, dz, 1'b0);
    run(30);

    // shadow update at cnt=4
    wait_cnt(4);
    d = '{7, 0, 10, 255};
    step(1'b1, 1'b1, 1'b1, 9, d, 1'b0);
    run(25);

    // load coinciding with the period end while another update is pending
    wait_cnt(2);
    d = '{5, 1, 2, 3};
    step(1'b1, 1'b1, 1'b1, 9, d, 1'b0);
    wait_cnt(9);
    d = '{2, 9, 4, 0};
    step(1'b1, 1'b1, 1'b1, 6, d, 1'b0);
    run(25);

    // center mode P=4, ch0 duty 2
    d = '{2, 4, 5, 0};
    step(1'b1, 1'b0, 1'b1, 4, d, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, dz, 1'b0);
    run(24);

    // mid-period reset at cnt=6 after a long edge period
    d = '{3, 6, 8, 1};
    step(1'b1, 1'b0, 1'b1, 12, d, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, dz, 1'b0);
    wait_cnt(6);
    d = '{1, 1, 1, 1};
    step(1'b1, 1'b1, 1'b1, 3, d, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, dz, 1'b0);
    run(20);

    // P=0 and P=1 corners in both modes
    for (int md = 0; md < 2; md++) begin
      for (int pp = 0; pp < 2; pp++) begin
        d = '{0, 1, 2, 3};
        step(1'b1, 1'b0, 1'b1, pp, d, md[0]);
        step(1'b1, 1'b0, 1'b0, 0, dz, 1'b0);
        run(8);
      end
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      p = $urandom_range(0, 12);
      for (int i = 0; i < CH; i++) d[i] = $urandom_range(0, p + 2);
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 7) == 0), p, d, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
